// File: rtl/cn_c2v_gen.sv
// Min-sum check-node c2v generator: row snapshot plus double-buffered v2c sign banks.
// Optional offset-min-sum correction is enabled by defining CN_C2V_OFFSET_EN.
module cn_c2v_gen #(
  parameter int MSG_WIDTH   = 6,
  parameter int COL_CNT_WID = 5,
  parameter int COL_NUM     = 32,
  parameter int OFFSET      = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_decode_end,
  input  logic                         i_sign_vld,
  input  logic [COL_CNT_WID-1:0]       i_sign_col,
  input  logic                         i_v2c_sign,
  input  logic                         i_load,
  input  logic [2*(MSG_WIDTH-1)-1:0]   i_v2c_abs,
  input  logic [COL_CNT_WID-1:0]       i_v2c_idx,
  input  logic                         i_v2c_sign_tot,
  input  logic                         i_req,
  input  logic [COL_CNT_WID-1:0]       i_col_cnt,
  output logic [MSG_WIDTH-1:0]         o_c2v,
  output logic                         o_c2v_vld,
  output logic [COL_CNT_WID-1:0]       o_c2v_col,
  output logic                         o_rdy
);

  localparam int ABS_WID = MSG_WIDTH - 1;

`ifdef CN_C2V_OFFSET_EN
  localparam bit OFS_EN = 1'b1;
`else
  localparam bit OFS_EN = 1'b0;
`endif
  // A zero offset reduces the saturating subtract to a pass-through.
  localparam logic [ABS_WID-1:0] OFS_V = OFS_EN ? ABS_WID'(OFFSET) : '0;
  localparam logic [COL_CNT_WID:0] COL_LIM = (COL_CNT_WID+1)'(COL_NUM);

  typedef enum logic {
    EMPTY = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                       r_rdy, rdy_nxt;
  logic [ABS_WID-1:0]           r_min1, r_min2;
  logic [COL_CNT_WID-1:0]       r_idx;
  logic                         r_stot;
  logic                         r_bsel;
  logic [1:0][COL_NUM-1:0]      r_bank, bank_nxt;

  logic                         wr_ok, rd_ok, req_ok, own_sign;
  logic [ABS_WID-1:0]           m_sel, mag;

  assign wr_ok  = i_sign_vld && ({1'b0, i_sign_col} < COL_LIM);
  assign rd_ok  = {1'b0, i_col_cnt} < COL_LIM;
  assign req_ok = i_req && (r_rdy == READY);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_rdy <= EMPTY;
    else          r_rdy <= rdy_nxt;
  end

  always_comb begin
    rdy_nxt = r_rdy;
    if (i_decode_end) rdy_nxt = EMPTY;
    else if (i_load)  rdy_nxt = READY;
  end

  // Same-cycle write lands in the outgoing collection bank; the other bank is wiped on swap.
  always_comb begin
    bank_nxt = r_bank;
    if (wr_ok)  bank_nxt[r_bsel][i_sign_col] = i_v2c_sign;
    if (i_load) bank_nxt[~r_bsel] = '0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_decode_end) begin
      r_min1 <= '0;
      r_min2 <= '0;
      r_idx  <= '0;
      r_stot <= 1'b0;
      r_bsel <= 1'b0;
      r_bank <= '0;
    end else begin
      r_bank <= bank_nxt;
      if (i_load) begin
        r_min1 <= i_v2c_abs[ABS_WID-1:0];
        r_min2 <= i_v2c_abs[2*ABS_WID-1:ABS_WID];
        r_idx  <= i_v2c_idx;
        r_stot <= i_v2c_sign_tot;
        r_bsel <= ~r_bsel;
      end
    end
  end

  always_comb begin
    m_sel    = (i_col_cnt == r_idx) ? r_min2 : r_min1;
    mag      = (m_sel > OFS_V) ? m_sel - OFS_V : '0;
    own_sign = rd_ok ? r_bank[~r_bsel][i_col_cnt] : 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_c2v     <= '0;
      o_c2v_vld <= 1'b0;
      o_c2v_col <= '0;
    end else if (i_decode_end) begin
      o_c2v_vld <= 1'b0;
    end else begin
      o_c2v_vld <= req_ok;
      if (req_ok) begin
        o_c2v     <= {r_stot ^ own_sign, mag};
        o_c2v_col <= i_col_cnt;
      end
    end
  end

  assign o_rdy = (r_rdy == READY);

endmodule

// File: tb/tb_cn_c2v_gen.sv
// Directed table-driven bench for cn_c2v_gen; expectations follow CN_C2V_OFFSET_EN if defined.
module tb_cn_c2v_gen;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_decode_end, i_sign_vld, i_v2c_sign, i_load, i_v2c_sign_tot, i_req;
  logic [4:0]  i_sign_col, i_v2c_idx, i_col_cnt;
  logic [9:0]  i_v2c_abs;
  logic [5:0]  o_c2v;
  logic        o_c2v_vld, o_rdy;
  logic [4:0]  o_c2v_col;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  cn_c2v_gen dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_decode_end(i_decode_end),
    .i_sign_vld(i_sign_vld), .i_sign_col(i_sign_col), .i_v2c_sign(i_v2c_sign),
    .i_load(i_load), .i_v2c_abs(i_v2c_abs), .i_v2c_idx(i_v2c_idx),
    .i_v2c_sign_tot(i_v2c_sign_tot), .i_req(i_req), .i_col_cnt(i_col_cnt),
    .o_c2v(o_c2v), .o_c2v_vld(o_c2v_vld), .o_c2v_col(o_c2v_col), .o_rdy(o_rdy)
  );

  typedef struct {
    logic       sv;  logic [4:0] scol; logic sgn;
    logic       ld;  logic [4:0] m1;   logic [4:0] m2; logic [4:0] idx; logic st;
    logic       rq;  logic [4:0] col;  logic de;
    logic       e_vld; logic e_rdy; logic ck; logic [5:0] e_c2v; logic [4:0] e_col;
  } vec_t;

  function automatic logic [4:0] mg(input logic [4:0] m);
`ifdef CN_C2V_OFFSET_EN
    return (m > 5'd1) ? m - 5'd1 : 5'd0;
`else
    return m;
`endif
  endfunction

  function automatic vec_t mk(
    input logic sv, input logic [4:0] scol, input logic sgn,
    input logic ld, input logic [4:0] m1, input logic [4:0] m2, input logic [4:0] idx, input logic st,
    input logic rq, input logic [4:0] col, input logic de,
    input logic e_vld, input logic e_rdy, input logic ck, input logic [5:0] e_c2v, input logic [4:0] e_col);
    vec_t v;
    v.sv = sv; v.scol = scol; v.sgn = sgn;
    v.ld = ld; v.m1 = m1; v.m2 = m2; v.idx = idx; v.st = st;
    v.rq = rq; v.col = col; v.de = de;
    v.e_vld = e_vld; v.e_rdy = e_rdy; v.ck = ck; v.e_c2v = e_c2v; v.e_col = e_col;
    return v;
  endfunction

  task automatic run(input vec_t v, input string name);
    i_sign_vld = v.sv; i_sign_col = v.scol; i_v2c_sign = v.sgn;
    i_load = v.ld; i_v2c_abs = {v.m2, v.m1}; i_v2c_idx = v.idx; i_v2c_sign_tot = v.st;
    i_req = v.rq; i_col_cnt = v.col; i_decode_end = v.de;
    @(posedge i_clk);
    #1;
    n_vec++;
    if (o_c2v_vld !== v.e_vld) begin
      n_err++;
      $display("FAIL %s vld: got %0b want %0b", name, o_c2v_vld, v.e_vld);
    end
    if (o_rdy !== v.e_rdy) begin
      n_err++;
      $display("FAIL %s rdy: got %0b want %0b", name, o_rdy, v.e_rdy);
    end
    if (v.ck) begin
      if (o_c2v !== v.e_c2v) begin
        n_err++;
        $display("FAIL %s c2v: got %h want %h", name, o_c2v, v.e_c2v);
      end
      if (o_c2v_col !== v.e_col) begin
        n_err++;
        $display("FAIL %s col: got %0d want %0d", name, o_c2v_col, v.e_col);
      end
    end
  endtask

  vec_t tbl[13];

  initial begin
    //             sv scol sg ld m1 m2 idx st rq col de  vld rdy ck c2v             col
    tbl[0]  = mk(0, 0,  0, 0, 0, 0, 0,  0, 1, 3,  0,  0, 0, 1, 6'h00,           0);
    tbl[1]  = mk(1, 2,  0, 0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0, 6'h00,           0);
    tbl[2]  = mk(1, 4,  1, 0, 0, 0, 0,  0, 0, 0,  0,  0, 0, 0, 6'h00,           0);
    tbl[3]  = mk(0, 0,  0, 1, 3, 7, 4,  1, 0, 0,  0,  0, 1, 0, 6'h00,           0);
    tbl[4]  = mk(0, 0,  0, 0, 0, 0, 0,  0, 1, 2,  0,  1, 1, 1, {1'b1, mg(5'd3)}, 2);
    tbl[5]  = mk(0, 0,  0, 0, 0, 0, 0,  0, 1, 4,  0,  1, 1, 1, {1'b0, mg(5'd7)}, 4);
    tbl[6]  = mk(0, 0,  0, 0, 0, 0, 0,  0, 0, 0,  0,  0, 1, 1, {1'b0, mg(5'd7)}, 4);
    tbl[7]  = mk(0, 0,  0, 0, 0, 0, 0,  0, 1, 31, 0,  1, 1, 1, {1'b1, mg(5'd3)}, 31);
    tbl[8]  = mk(0, 0,  0, 1, 0, 5, 1,  0, 0, 0,  0,  0, 1, 0, 6'h00,           0);
    tbl[9]  = mk(0, 0,  0, 0, 0, 0, 0,  0, 1, 0,  0,  1, 1, 1, 6'h00,           0);
    tbl[10] = mk(0, 0,  0, 0, 0, 0, 0,  0, 1, 1,  0,  1, 1, 1, {1'b0, mg(5'd5)}, 1);
    tbl[11] = mk(0, 0,  0, 1, 1, 2, 0,  1, 0, 0,  0,  0, 1, 0, 6'h00,           0);
    tbl[12] = mk(0, 0,  0, 0, 0, 0, 0,  0, 1, 5,  0,  1, 1, 1, {1'b1, mg(5'd1)}, 5);

    // Reset
    i_rst_n = 1'b0;
    run(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,1,6'h00,0), "reset");
    i_rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run(tbl[i], $sformatf("tbl%0d", i));

    // Bank swap: row A all ones, col0 written on the same cycle as row A's load
    run(mk(0,0,0,0,0,0,0,0,0,0,1, 0,0,0,6'h00,0), "clr");
    for (int c = 1; c < 32; c++) run(mk(1,c[4:0],1,0,0,0,0,0,0,0,0, 0,0,0,6'h00,0), "rowA_wr");
    run(mk(1,0,1, 1,4,6,20,0, 0,0,0, 0,1,0,6'h00,0), "rowA_ld");
    run(mk(0,0,0,0,0,0,0,0, 1,0,0,  1,1,1,{1'b1,mg(5'd4)},0),  "rowA_c0");
    run(mk(0,0,0,0,0,0,0,0, 1,7,0,  1,1,1,{1'b1,mg(5'd4)},7),  "rowA_c7");
    run(mk(0,0,0,0,0,0,0,0, 1,20,0, 1,1,1,{1'b1,mg(5'd6)},20), "rowA_c20");
    run(mk(1,0,0,0,0,0,0,0, 0,0,0,  0,1,0,6'h00,0), "rowB_w0");
    run(mk(1,3,1,0,0,0,0,0, 0,0,0,  0,1,0,6'h00,0), "rowB_w3");
    run(mk(0,0,0, 1,2,9,3,0, 0,0,0, 0,1,0,6'h00,0), "rowB_ld");
    run(mk(0,0,0,0,0,0,0,0, 1,0,0,  1,1,1,{1'b0,mg(5'd2)},0), "rowB_c0");
    run(mk(0,0,0,0,0,0,0,0, 1,3,0,  1,1,1,{1'b1,mg(5'd9)},3), "rowB_c3");
    run(mk(0,0,0,0,0,0,0,0, 1,7,0,  1,1,1,{1'b0,mg(5'd2)},7), "rowB_c7");
    run(mk(0,0,0, 1,10,12,9,0, 0,0,0, 0,1,0,6'h00,0), "rowC_ld");
    run(mk(0,0,0,0,0,0,0,0, 1,7,0,  1,1,1,{1'b0,mg(5'd10)},7), "rowC_c7");

    // Load and request in the same cycle
    run(mk(0,0,0, 1,3,12,30,0, 0,0,0, 0,1,0,6'h00,0), "ldD");
    run(mk(0,0,0, 1,9,11,30,0, 1,5,0, 1,1,1,{1'b0,mg(5'd3)},5), "ld_req_old");
    run(mk(0,0,0,0,0,0,0,0, 1,5,0,   1,1,1,{1'b0,mg(5'd9)},5), "ld_req_new");

    // Decode end wins over load and request
    run(mk(0,0,0, 1,7,8,0,0, 1,5,1,  0,0,1,{1'b0,mg(5'd9)},5), "de_all");
    run(mk(0,0,0,0,0,0,0,0, 1,5,0,   0,0,1,{1'b0,mg(5'd9)},5), "de_drop");
    run(mk(0,0,0, 1,4,8,0,0, 0,0,0,  0,1,0,6'h00,0), "de_reld");
    run(mk(0,0,0,0,0,0,0,0, 1,2,0,   1,1,1,{1'b0,mg(5'd4)},2), "de_req");

    // Mid-stream reset clears outputs
    run(mk(0,0,0,0,0,0,0,0, 1,6,0,   1,1,1,{1'b0,mg(5'd4)},6), "pre_rst");
    i_rst_n = 1'b0;
    run(mk(0,0,0,0,0,0,0,0, 1,6,0,   0,0,1,6'h00,0), "mid_rst");
    i_rst_n = 1'b1;
    run(mk(0,0,0,0,0,0,0,0, 1,6,0,   0,0,1,6'h00,0), "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
